// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered ALU: operation codes and FSM state type.
// Imported by the interface-level top and the iterative datapath.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1011;
    localparam logic [3:0] ALU_MULU = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    function automatic logic is_iterative(input logic [3:0] ctrl);
        return (ctrl == ALU_MULU) || (ctrl == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the datapath controller and alu_seq.
// ovf_o exists only when ALU_SEQ_OVERFLOW_EN is defined.
interface alu_seq_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic              start_i;
    logic [WIDTH-1:0]  src1_i;
    logic [WIDTH-1:0]  src2_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              busy_o;
    logic              done_o;
    logic [WIDTH-1:0]  result_o;
    logic [WIDTH-1:0]  result_hi_o;
    logic              zero_o;
`ifdef ALU_SEQ_OVERFLOW_EN
    logic              ovf_o;
`endif

    modport master (
        output start_i, src1_i, src2_i, ctrl_i,
        input  busy_o, done_o, result_o, result_hi_o, zero_o
`ifdef ALU_SEQ_OVERFLOW_EN
        , input ovf_o
`endif
    );

    modport slave (
        input  start_i, src1_i, src2_i, ctrl_i,
        output busy_o, done_o, result_o, result_hi_o, zero_o
`ifdef ALU_SEQ_OVERFLOW_EN
        , output ovf_o
`endif
    );

endinterface

// File: rtl/alu_seq_iter.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// One step per cycle; the next-step values are exposed so the final step can be registered directly.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_next_o,
    output logic [WIDTH-1:0] lo_next_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_fits;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_shf;

    // acc holds product-high / partial remainder, shf holds multiplier / dividend-becoming-quotient
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q, shf_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opd_q});
        div_sub   = div_shift[WIDTH-1:0] - opd_q;

        if (div_q) begin
            step_acc = div_fits ? div_sub : div_shift[WIDTH-1:0];
            step_shf = {shf_q[WIDTH-2:0], div_fits};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_shf = {mul_sum[0], shf_q[WIDTH-1:1]};
        end

        hi_next_o = step_acc;
        lo_next_o = step_shf;
    end

    always_comb begin
        acc_d = acc_q;
        shf_d = shf_q;
        opd_d = opd_q;
        div_d = div_q;
        if (load_i) begin
            acc_d = '0;
            shf_d = div_mode_i ? a_i : b_i;
            opd_d = div_mode_i ? b_i : a_i;
            div_d = div_mode_i;
        end else if (step_i) begin
            acc_d = step_acc;
            shf_d = step_shf;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            shf_q <= '0;
            opd_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            shf_q <= shf_d;
            opd_q <= opd_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake; MULU/DIVU take WIDTH+1 cycles, others 1.
// Define ALU_SEQ_OVERFLOW_EN to add the signed ADD/SUB overflow flag ovf_o.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  CTRL_W = 4,
    localparam int CNT_W  = $clog2(WIDTH) + 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    alu_seq_if.slave bus
);

    localparam int SH_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic             iter_load;
    logic             iter_step;
    logic             div_mode;

`ifdef ALU_SEQ_OVERFLOW_EN
    logic             ovf_q, ovf_d;
    logic             add_ovf;
    logic             sub_ovf;
`endif

    assign div_mode = (bus.ctrl_i == ALU_DIVU);

    alu_seq_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (iter_load),
        .step_i     (iter_step),
        .div_mode_i (div_mode),
        .a_i        (bus.src1_i),
        .b_i        (bus.src2_i),
        .hi_next_o  (iter_hi),
        .lo_next_o  (iter_lo)
    );

    always_comb begin
        sum    = bus.src1_i + bus.src2_i;
        diff   = bus.src1_i - bus.src2_i;
        op_res = '0;
        case (bus.ctrl_i)
            ALU_AND:  op_res = bus.src1_i & bus.src2_i;
            ALU_OR:   op_res = bus.src1_i | bus.src2_i;
            ALU_ADD:  op_res = sum;
            ALU_SUB:  op_res = diff;
            ALU_SLTU: op_res = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
            ALU_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            ALU_SRA:  op_res = $signed(bus.src1_i) >>> bus.src2_i[SH_W-1:0];
            ALU_LUI:  op_res = bus.src2_i << (WIDTH/2);
            default:  op_res = '0;
        endcase
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    always_comb begin
        add_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) && (sum[WIDTH-1]  != bus.src1_i[WIDTH-1]);
        sub_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) && (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
    end
`endif

    // DONE accepts a new request just like IDLE, giving back-to-back throughput
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        iter_load   = 1'b0;
        iter_step   = 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start_i) begin
                    if (is_iterative(bus.ctrl_i)) begin
                        state_d   = CALC;
                        cnt_d     = CNT_W'(WIDTH);
                        iter_load = 1'b1;
                    end else begin
                        state_d     = DONE;
                        result_d    = op_res;
                        result_hi_d = '0;
                        zero_d      = (op_res == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                        ovf_d = ((bus.ctrl_i == ALU_ADD) && add_ovf) ||
                                ((bus.ctrl_i == ALU_SUB) && sub_ovf);
`endif
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                iter_step = 1'b1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    result_d    = iter_lo;
                    result_hi_d = iter_hi;
                    zero_d      = (iter_lo == '0);
`ifdef ALU_SEQ_OVERFLOW_EN
                    ovf_d       = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
`ifdef ALU_SEQ_OVERFLOW_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.busy_o      = (state_q == CALC);
    assign bus.done_o      = (state_q == DONE);
    assign bus.result_o    = result_q;
    assign bus.result_hi_o = result_hi_q;
    assign bus.zero_o      = zero_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    assign bus.ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a cycle-countdown reference model compared every cycle,
// plus directed vectors with literal expectations, and a WIDTH=8 multiply instance.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32), .CTRL_W(4)) bus ();
    alu_seq_if #(.WIDTH(8),  .CTRL_W(4)) bus8 ();

    alu_seq #(.WIDTH(32), .CTRL_W(4)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    alu_seq #(.WIDTH(8), .CTRL_W(4)) u_dut8 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 'left' counts cycles up to and including the done cycle
    int          left     = 0;
    logic        model_on = 1'b0;
    logic [31:0] exp_res  = '0;
    logic [31:0] exp_hi   = '0;
    logic        exp_ovf  = 1'b0;
    logic [64:0] pend;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    function automatic logic [64:0] golden(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        logic [63:0] p;
        longint      s;
        lo  = '0;
        hi  = '0;
        ovf = 1'b0;
        case (op)
            ALU_AND:  lo = a & b;
            ALU_OR:   lo = a | b;
            ALU_ADD: begin
                lo  = a + b;
                s   = longint'($signed(a)) + longint'($signed(b));
                ovf = (s > SMAX) || (s < SMIN);
            end
            ALU_SUB: begin
                lo  = a - b;
                s   = longint'($signed(a)) - longint'($signed(b));
                ovf = (s > SMAX) || (s < SMIN);
            end
            ALU_SLTU: lo = (a < b) ? 32'd1 : 32'd0;
            ALU_SLT:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SRA:  lo = $signed(a) >>> b[4:0];
            ALU_LUI:  lo = b << 16;
            ALU_MULU: begin
                p  = 64'(a) * 64'(b);
                lo = p[31:0];
                hi = p[63:32];
            end
            ALU_DIVU: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: lo = '0;
        endcase
        return {ovf, hi, lo};
    endfunction

    function automatic int latency(input logic [3:0] op);
        return ((op == ALU_MULU) || (op == ALU_DIVU)) ? 33 : 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            left     = 0;
            exp_res  = '0;
            exp_hi   = '0;
            exp_ovf  = 1'b0;
            model_on = 1'b1;
        end else if (bus.start_i && left <= 1) begin
            pend = golden(bus.ctrl_i, bus.src1_i, bus.src2_i);
            left = latency(bus.ctrl_i);
            if (left == 1) {exp_ovf, exp_hi, exp_res} = pend;
        end else if (left > 0) begin
            left = left - 1;
            if (left == 1) {exp_ovf, exp_hi, exp_res} = pend;
        end
    end

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check_output("mdl_busy",   64'(bus.busy_o),      64'(left > 1));
            check_output("mdl_done",   64'(bus.done_o),      64'(left == 1));
            check_output("mdl_result", 64'(bus.result_o),    64'(exp_res));
            check_output("mdl_hi",     64'(bus.result_hi_o), 64'(exp_hi));
            check_output("mdl_zero",   64'(bus.zero_o),      64'(exp_res == 0));
`ifdef ALU_SEQ_OVERFLOW_EN
            check_output("mdl_ovf",    64'(bus.ovf_o),       64'(exp_ovf));
`endif
        end
    end

    task automatic set_inputs(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start_i = 1'b1;
        bus.ctrl_i  = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        set_inputs(op, a, b);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int lat;
        lat = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (bus.done_o) begin
                lat = n;
                break;
            end
        end
        check_output({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int pulses;
        int lat8;

        vecs = '{
            '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b1, 1},
            '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 32'h0,        1'b0, 1},
            '{ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b1, 1},
            '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1},
            '{ALU_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 32'h0,        1'b0, 1},
            '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        1'b0, 1},
            '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1},
            '{ALU_AND,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h0,        1'b0, 1},
            '{ALU_OR,   32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 32'h0,        1'b0, 1},
            '{ALU_LUI,  32'h12345678, 32'h0000ABCD, 32'hABCD0000, 32'h0,        1'b0, 1},
            '{4'b0011,  32'h00000001, 32'h00000002, 32'h00000000, 32'h0,        1'b0, 1},
            '{ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33},
            '{ALU_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 33},
            '{ALU_DIVU, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 33}
        };

        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.ctrl_i   = '0;
        bus.src1_i   = '0;
        bus.src2_i   = '0;
        bus8.start_i = 1'b0;
        bus8.ctrl_i  = '0;
        bus8.src1_i  = '0;
        bus8.src2_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check_output("rst_result", 64'(bus.result_o),  64'h0);
        check_output("rst_zero",   64'(bus.zero_o),    64'h1);
        check_output("rst_busy",   64'(bus.busy_o),    64'h0);
        check_output("rst8_zero",  64'(bus8.zero_o),   64'h1);

        // Reset in the middle of a multiply must abort it silently
        apply_stimulus(ALU_MULU, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("abort_busy", 64'(bus.busy_o), 64'h0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o) pulses++;
        end
        check_output("abort_no_done", 64'(pulses),        64'h0);
        check_output("abort_result",  64'(bus.result_o),  64'h0);
        check_output("abort_zero",    64'(bus.zero_o),    64'h1);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].lat);
            check_output($sformatf("vec%0d_result", i), 64'(bus.result_o),    64'(vecs[i].lo));
            check_output($sformatf("vec%0d_hi", i),     64'(bus.result_hi_o), 64'(vecs[i].hi));
            check_output($sformatf("vec%0d_zero", i),   64'(bus.zero_o),      64'(vecs[i].lo == 0));
`ifdef ALU_SEQ_OVERFLOW_EN
            check_output($sformatf("vec%0d_ovf", i),    64'(bus.ovf_o),       64'(vecs[i].ovf));
`endif
        end

        // Requests while busy are dropped, not queued
        @(posedge clk);
        #1;
        set_inputs(ALU_MULU, 32'd6, 32'd7);
        @(posedge clk);
        #1;
        set_inputs(ALU_ADD, 32'd1, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_done("hold", 23);
        check_output("hold_result", 64'(bus.result_o),    64'd42);
        check_output("hold_hi",     64'(bus.result_hi_o), 64'd0);

        // New requests issued in the DONE cycle
        apply_stimulus(ALU_MULU, 32'd12, 32'd13);
        wait_done("b2b_mul", 33);
        check_output("b2b_mul_result", 64'(bus.result_o), 64'd156);
        set_inputs(ALU_DIVU, 32'd1000, 32'd33);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_done("b2b_div", 33);
        check_output("b2b_div_result", 64'(bus.result_o),    64'd30);
        check_output("b2b_div_hi",     64'(bus.result_hi_o), 64'd10);
        set_inputs(ALU_SUB, 32'd10, 32'd3);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        wait_done("b2b_sub", 1);
        check_output("b2b_sub_result", 64'(bus.result_o),    64'd7);
        check_output("b2b_sub_hi",     64'(bus.result_hi_o), 64'd0);

        // Narrow instance: 8-bit multiply completes in WIDTH+1 = 9 cycles
        @(posedge clk);
        #1;
        bus8.start_i = 1'b1;
        bus8.ctrl_i  = ALU_MULU;
        bus8.src1_i  = 8'hFF;
        bus8.src2_i  = 8'hFF;
        @(posedge clk);
        #1;
        bus8.start_i = 1'b0;
        lat8 = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) check_output("w8_busy", 64'(bus8.busy_o), 64'h1);
            if (bus8.done_o) begin
                lat8 = n;
                break;
            end
        end
        check_output("w8_latency", 64'(lat8),             64'd9);
        check_output("w8_lo",      64'(bus8.result_o),    64'h01);
        check_output("w8_hi",      64'(bus8.result_hi_o), 64'hFE);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
